// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds the PLL in reset, waits for a filtered lock with timeout,
// then releases the system reset; re-sequences on lock loss or software request.
`default_nettype none

module pll_reset_sequencer #(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int LOCK_FILTER     = 256,
  parameter int LOCK_TIMEOUT    = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       refclk_i,
  input  logic       rst_n_i,
  input  logic       pll_locked_i,
  input  logic       soft_reset_i,
  output logic       pll_rst_o,
  output logic       sys_rst_n_o,
  output logic [1:0] seq_state_o,
  output logic       timeout_flag_o,
  output logic [7:0] lock_loss_cnt_o,
  output logic [7:0] retry_cnt_o
);

  localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int FILT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int TMO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_FILTER    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic [FILT_W-1:0]        filt_q, filt_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     flag_q, flag_d;
  logic [7:0]               loss_q, loss_d;
  logic [7:0]               retry_q, retry_d;
  logic                     pll_rst_q, sys_rst_n_q;
  logic                     locked_s;
  logic                     timeout_hit;

  assign locked_s    = sync_q[SYNC_STAGES-1];
  assign timeout_hit = (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    filt_d  = filt_q;
    tmo_d   = tmo_q;
    flag_d  = flag_q;
    loss_d  = loss_q;
    retry_d = retry_q;

    case (state_q)
      ST_RESET_PLL: begin
        if (soft_reset_i) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
          tmo_d   = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        if (soft_reset_i) begin
          state_d = ST_RESET_PLL;
        end else if (timeout_hit) begin
          state_d = ST_RESET_PLL;
          flag_d  = 1'b1;
          retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (locked_s) begin
            state_d = ST_FILTER;
            filt_d  = '0;
          end
        end
      end

      ST_FILTER: begin
        // Timeout is checked first so it wins over a simultaneous filter completion.
        if (soft_reset_i) begin
          state_d = ST_RESET_PLL;
        end else if (timeout_hit) begin
          state_d = ST_RESET_PLL;
          flag_d  = 1'b1;
          retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
        end else if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          tmo_d   = tmo_q + TMO_W'(1);
        end else if (filt_q == FILT_LAST) begin
          state_d = ST_RUN;
        end else begin
          filt_d = filt_q + FILT_W'(1);
          tmo_d  = tmo_q + TMO_W'(1);
        end
      end

      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_RESET_PLL;
          loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
        end else if (soft_reset_i) begin
          state_d = ST_RESET_PLL;
        end
      end

      default: state_d = ST_RESET_PLL;
    endcase
  end

  always_ff @(posedge refclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_RESET_PLL;
      sync_q      <= '0;
      hold_q      <= '0;
      filt_q      <= '0;
      tmo_q       <= '0;
      flag_q      <= 1'b0;
      loss_q      <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
      hold_q      <= hold_d;
      filt_q      <= filt_d;
      tmo_q       <= tmo_d;
      flag_q      <= flag_d;
      loss_q      <= loss_d;
      retry_q     <= retry_d;
      pll_rst_q   <= (state_d == ST_RESET_PLL);
      sys_rst_n_q <= (state_d == ST_RUN);
    end
  end

  assign pll_rst_o       = pll_rst_q;
  assign sys_rst_n_o     = sys_rst_n_q;
  assign seq_state_o     = state_q;
  assign timeout_flag_o  = flag_q;
  assign lock_loss_cnt_o = loss_q;
  assign retry_cnt_o     = retry_q;

endmodule

`default_nettype wire
